pc_fetch: RTL

Program-counter register and instruction-fetch sequencer for the multi-cycle RV32I core. It holds the architectural PC and fetches the instruction at that address through a request/grant/response instruction-memory port. It presents the fetched word to decode with a valid/ready handshake, then waits for the next-PC value from the next-PC logic before starting the next fetch. Only one instruction is in flight at a time.

---
 rtl/pc_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC register and single-outstanding instruction-fetch sequencer.
// Latency: best case 4 cycles per instruction (REQ, WAIT, OUT, EXEC); each extra cycle of
// gnt/rvalid/inst_ready/npc_valid latency adds one. Backpressure: inst held stable until inst_ready.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        misalign,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    RST  = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    EXEC = 3'd4,
    HALT = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // A next PC is only usable when it is word aligned; anything else stops fetch.
  logic npc_aligned;
  assign npc_aligned = (npc[1:0] == 2'b00);

  // The address bus always carries the PC; the memory only looks at it while imem_req is high.
  assign imem_addr = pc;

  // Fetch sequencer: one instruction in flight, outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RST;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      retired    <= 32'h0;
      misalign   <= 1'b0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        RST: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end

        // Hold the request (and address) until the memory grants it; rvalid is not looked at.
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end

        // Capture the returned word together with the PC it was fetched from.
        WAIT: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= OUT;
          end
        end

        // Present to decode; npc_valid here belongs to nobody and is dropped.
        OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= EXEC;
          end
        end

        // Wait for the next PC; a misaligned target freezes pc/retired and stops fetch for good.
        EXEC: begin
          if (npc_valid) begin
            if (npc_aligned) begin
              pc       <= npc;
              retired  <= retired + 32'd1;
              imem_req <= 1'b1;
              state    <= REQ;
            end else begin
              misalign <= 1'b1;
              state    <= HALT;
            end
          end
        end

        // Parked until reset; misalign stays set.
        HALT: begin
          state <= HALT;
        end

        default: begin
          state      <= RST;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
